// File: rtl/mio_responder_if.sv
// CPU memory/IO bus bundle between the CPU (master) and the responder (slave).
interface mio_responder_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [31:0] Data_in;
    logic        MIO_ready;
    logic        bus_err;

    modport master (
        output CPU_MIO, mem_w, Addr_out, Data_out,
        input  Data_in, MIO_ready, bus_err
    );

    modport slave (
        input  CPU_MIO, mem_w, Addr_out, Data_out,
        output Data_in, MIO_ready, bus_err
    );
endinterface

// File: rtl/mio_responder.sv
// Memory/IO bus responder: word RAM plus GPIO/counter registers with programmable wait states.
// Optional macro MIO_FAST_WRITE_EN: writes bypass the wait states (IDLE -> ACCESS).
module mio_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] IO_BASE     = 32'hF000_0000
) (
    input  logic              clk,
    input  logic              reset,
    mio_responder_if.slave    bus,
    output logic [15:0]       gpio_out,
    input  logic [15:0]       gpio_in
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [32:0] RAM_LIMIT  = 33'(DEPTH) * 33'd4;
    localparam bit          HAS_WAIT   = (WAIT_CYCLES > 0);
    localparam logic [3:0]  WAIT_LOAD  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [31:0] IO_GPIO_OUT = IO_BASE;
    localparam logic [31:0] IO_GPIO_IN  = IO_BASE + 32'd4;
    localparam logic [31:0] IO_CNT      = IO_BASE + 32'd8;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  wcnt_reg, wcnt_next;

    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        we_reg;

    logic [15:0] gpio_reg;
    logic [31:0] cnt_reg;
    logic [31:0] io_rdata_reg;
    logic        sel_ram_reg;
    logic        err_reg;

    logic [31:0] mem [DEPTH];
    logic [31:0] ram_rdata_reg;

    logic        fast_wr;
    logic        ram_hit, hit_gpio_out, hit_gpio_in, hit_cnt, unmapped;
    logic        in_access;
    logic [AW-1:0] ram_idx;

`ifdef MIO_FAST_WRITE_EN
    assign fast_wr = bus.mem_w;
`else
    assign fast_wr = 1'b0;
`endif

    // Decode works on the latched request only; low two address bits are ignored.
    assign ram_hit      = ({1'b0, addr_reg} < RAM_LIMIT);
    assign hit_gpio_out = (addr_reg[31:2] == IO_GPIO_OUT[31:2]);
    assign hit_gpio_in  = (addr_reg[31:2] == IO_GPIO_IN[31:2]);
    assign hit_cnt      = (addr_reg[31:2] == IO_CNT[31:2]);
    assign unmapped     = !(ram_hit || hit_gpio_out || hit_gpio_in || hit_cnt);
    assign ram_idx      = addr_reg[AW+1:2];
    assign in_access    = reset && (state_reg == ACCESS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            wcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.CPU_MIO) begin
                    if (HAS_WAIT && !fast_wr) begin
                        state_next = WAIT;
                        wcnt_next  = WAIT_LOAD;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (wcnt_reg == 4'd0) state_next = ACCESS;
                else                  wcnt_next  = wcnt_reg - 4'd1;
            end
            ACCESS: state_next = RESP;
            RESP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
        end else if (state_reg == IDLE && bus.CPU_MIO) begin
            addr_reg  <= bus.Addr_out;
            wdata_reg <= bus.Data_out;
            we_reg    <= bus.mem_w;
        end
    end

    // RAM has no reset; a write aborted by reset at its ACCESS edge is not committed.
    always_ff @(posedge clk) begin
        if (in_access && ram_hit && we_reg)
            mem[ram_idx] <= wdata_reg;
        if (in_access && ram_hit && !we_reg)
            ram_rdata_reg <= mem[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gpio_reg     <= '0;
            cnt_reg      <= '0;
            io_rdata_reg <= '0;
            sel_ram_reg  <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            cnt_reg <= cnt_reg + 32'd1;
            if (state_reg == ACCESS) begin
                sel_ram_reg  <= ram_hit && !we_reg;
                err_reg      <= unmapped;
                io_rdata_reg <= '0;
                if (we_reg) begin
                    if (hit_gpio_out) gpio_reg <= wdata_reg[15:0];
                    if (hit_cnt)      cnt_reg  <= '0;
                end else begin
                    if (hit_gpio_out) io_rdata_reg <= {16'b0, gpio_reg};
                    if (hit_gpio_in)  io_rdata_reg <= {16'b0, gpio_in};
                    if (hit_cnt)      io_rdata_reg <= cnt_reg;
                end
            end
        end
    end

    // Read-data sources only change on an ACCESS edge, so Data_in holds between responses.
    assign bus.Data_in   = sel_ram_reg ? ram_rdata_reg : io_rdata_reg;
    assign bus.MIO_ready = (state_reg == RESP);
    assign bus.bus_err   = (state_reg == RESP) && err_reg;
    assign gpio_out      = gpio_reg;

endmodule

// File: tb/tb_mio_responder.sv
// Directed, table-driven bench for mio_responder (WAIT_CYCLES=2, DEPTH=1024).
module tb_mio_responder;

    localparam int          W       = 2;
    localparam int          DEPTH   = 1024;
    localparam logic [31:0] IO      = 32'hF000_0000;
    localparam int          RD_LAT  = W + 1;
`ifdef MIO_FAST_WRITE_EN
    localparam int          WR_LAT  = 1;
`else
    localparam int          WR_LAT  = W + 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;
    int          total;
    int          bad;
    int unsigned tb_cyc;

    mio_responder_if bus ();

    mio_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .IO_BASE(IO)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (bus),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count since reset release, for the free-running counter.
    always @(posedge clk) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] gin;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [15:0] exp_gpio;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the response.
    task automatic do_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat,
                          output logic rdy_after, output int unsigned v);
        bus.CPU_MIO  = 1'b1;
        bus.mem_w    = we;
        bus.Addr_out = a;
        bus.Data_out = d;
        v = tb_cyc;
        @(posedge clk);
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.MIO_ready) begin
                rd = bus.Data_in;
                er = bus.bus_err;
                break;
            end
        end
        bus.CPU_MIO = 1'b0;
        @(negedge clk);
        rdy_after = bus.MIO_ready;
        $display("txn we=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d", we, a, d, rd, er, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er, rdy_after;
        int          lat, gap, n, rdy_cnt;
        int unsigned v, v_w;
        logic [31:0] b2b_addr[3];
        logic [31:0] b2b_exp[3];

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.CPU_MIO  = 1'b0;
        bus.mem_w    = 1'b0;
        bus.Addr_out = '0;
        bus.Data_out = '0;
        gpio_in      = '0;

        vt[0]  = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 16'h0000, 32'h0,         1'b0, 16'h0000};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         16'h0000, 32'hCAFE_F00D, 1'b0, 16'h0000};
        vt[2]  = '{1'b1, IO,            32'h0001_A5A5, 16'h0000, 32'h0,         1'b0, 16'hA5A5};
        vt[3]  = '{1'b0, IO,            32'h0,         16'h0000, 32'h0000_A5A5, 1'b0, 16'hA5A5};
        vt[4]  = '{1'b0, IO + 32'd4,    32'h0,         16'h1234, 32'h0000_1234, 1'b0, 16'hA5A5};
        vt[5]  = '{1'b1, IO + 32'd4,    32'hFFFF_FFFF, 16'h1234, 32'h0,         1'b0, 16'hA5A5};
        vt[6]  = '{1'b0, IO + 32'd4,    32'h0,         16'hBEEF, 32'h0000_BEEF, 1'b0, 16'hA5A5};
        vt[7]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 16'hBEEF, 32'h0,         1'b0, 16'hA5A5};
        vt[8]  = '{1'b1, 32'h0000_0004, 32'h2222_2222, 16'hBEEF, 32'h0,         1'b0, 16'hA5A5};
        vt[9]  = '{1'b1, 32'h0000_0008, 32'h3333_3333, 16'hBEEF, 32'h0,         1'b0, 16'hA5A5};
        vt[10] = '{1'b0, 32'h0000_0013, 32'h0,         16'hBEEF, 32'hCAFE_F00D, 1'b0, 16'hA5A5};
        vt[11] = '{1'b0, 32'h8000_0000, 32'h0,         16'hBEEF, 32'h0,         1'b1, 16'hA5A5};
        vt[12] = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 16'hBEEF, 32'h0,         1'b1, 16'hA5A5};
        vt[13] = '{1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 16'hBEEF, 32'h0,         1'b0, 16'hA5A5};
        vt[14] = '{1'b0, 32'h0000_0FFC, 32'h0,         16'hBEEF, 32'h5A5A_5A5A, 1'b0, 16'hA5A5};
        vt[15] = '{1'b0, 32'h0000_1000, 32'h0,         16'hBEEF, 32'h0,         1'b1, 16'hA5A5};
        vt[16] = '{1'b0, 32'h0000_0000, 32'h0,         16'hBEEF, 32'h1111_1111, 1'b0, 16'hA5A5};
        vt[17] = '{1'b0, IO + 32'd12,   32'h0,         16'hBEEF, 32'h0,         1'b1, 16'hA5A5};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_data_in",   bus.Data_in,           32'h0);
        chk("reset_ready",     {31'b0, bus.MIO_ready}, 32'h0);
        chk("reset_gpio_out",  {16'b0, gpio_out},      32'h0);
        chk("reset_bus_err",   {31'b0, bus.bus_err},   32'h0);

        do_txn(1'b0, IO + 32'd8, 32'h0, rd, er, lat, rdy_after, v);
        chk("cnt_first_read", rd, v + W + 1);
        chk("cnt_first_lat",  lat, RD_LAT);

        for (int i = 0; i < 18; i++) begin
            gpio_in = vt[i].gin;
            do_txn(vt[i].we, vt[i].addr, vt[i].wdata, rd, er, lat, rdy_after, v);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i),   {31'b0, er}, {31'b0, vt[i].exp_err});
            chk($sformatf("vec%0d_lat", i),   lat, vt[i].we ? WR_LAT : RD_LAT);
            chk($sformatf("vec%0d_width", i), {31'b0, rdy_after}, 32'h0);
            chk($sformatf("vec%0d_gpio", i),  {16'b0, gpio_out}, {16'b0, vt[i].exp_gpio});
        end

        // Counter clear: it restarts from 0 on the write's ACCESS edge.
        do_txn(1'b1, IO + 32'd8, 32'h1234_5678, rd, er, lat, rdy_after, v_w);
        do_txn(1'b0, IO + 32'd8, 32'h0, rd, er, lat, rdy_after, v);
        chk("cnt_after_clear", rd, v - v_w - 1);

        // Back-to-back reads with CPU_MIO held high.
        b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4; b2b_addr[2] = 32'h8;
        b2b_exp[0]  = 32'h1111_1111; b2b_exp[1] = 32'h2222_2222; b2b_exp[2] = 32'h3333_3333;
        bus.CPU_MIO  = 1'b1;
        bus.mem_w    = 1'b0;
        bus.Addr_out = b2b_addr[0];
        n   = 0;
        gap = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            if (bus.MIO_ready) begin
                $display("txn b2b%0d addr=%h rdata=%h gap=%0d", n, b2b_addr[n], bus.Data_in, gap);
                chk($sformatf("b2b%0d_rdata", n), bus.Data_in, b2b_exp[n]);
                if (n > 0) chk($sformatf("b2b%0d_gap", n), gap, W + 2);
                n++;
                gap = 0;
                if (n < 3) bus.Addr_out = b2b_addr[n];
                else       bus.CPU_MIO  = 1'b0;
            end else begin
                gap++;
            end
        end
        bus.CPU_MIO = 1'b0;
        chk("b2b_count", n, 3);
        @(negedge clk);

        // Reset asserted during WAIT of a write: aborted, no response, RAM untouched.
        bus.CPU_MIO  = 1'b1;
        bus.mem_w    = 1'b1;
        bus.Addr_out = 32'h10;
        bus.Data_out = 32'h0BAD_0BAD;
        @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.CPU_MIO = 1'b0;
        rdy_cnt     = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.MIO_ready) rdy_cnt++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.MIO_ready) rdy_cnt++;
        end
        $display("txn reset_abort write addr=00000010 ready_pulses=%0d", rdy_cnt);
        chk("abort_no_ready",  rdy_cnt, 0);
        chk("abort_gpio_out",  {16'b0, gpio_out}, 32'h0);
        chk("abort_data_in",   bus.Data_in, 32'h0);
        do_txn(1'b0, 32'h10, 32'h0, rd, er, lat, rdy_after, v);
        chk("abort_ram_kept",  rd, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mio_responder.md
Name: mio_responder

Overview:
- Memory/IO bus responder on the target side of the CPU memory interface.
- Samples the CPU request (CPU_MIO, mem_w, Addr_out, Data_out) and serves it from a local word RAM or a small memory-mapped IO register set.
- Returns read data on Data_in and signals completion with a one-cycle MIO_ready pulse after programmable wait states.
- Sits between the CPU and board IO; replaces the ad-hoc RAM/IO glue.

Parameters:
- DEPTH, 1024, RAM words; power of two; RAM region is byte addresses 0 .. DEPTH*4-1.
- WAIT_CYCLES, 2, extra wait states inserted before every response; range 0..15.
- IO_BASE, 32'hF000_0000, base address of the IO register block.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- CPU_MIO  in  1  request valid; held high by the CPU until MIO_ready.
- mem_w  in  1  1 = write, 0 = read; qualified by CPU_MIO.
- Addr_out  in  32  byte address; bits [1:0] ignored (word access only).
- Data_out  in  32  write data from the CPU.
- Data_in  out  32  read data to the CPU.
- MIO_ready  out  1  one-cycle completion pulse.
- gpio_out  out  16  GPIO output register.
- gpio_in  in  16  GPIO input pins, already synchronised externally.
- bus_err  out  1  one-cycle pulse on an access to an unmapped address.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; Data_in=0, MIO_ready=0, gpio_out=0, bus_err=0.
  - Cycle counter=0, wait counter=0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: on an edge with CPU_MIO=1, latch addr, wdata and we. Go to WAIT with wait counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else go to ACCESS.
  - WAIT: decrement each edge; at 0 go to ACCESS.
  - ACCESS: perform the decoded read or write (synchronous RAM, one edge), then go to RESP.
  - RESP: MIO_ready=1 for exactly this cycle; Data_in=read result. Next edge returns to IDLE.
- Latency: request sampled at edge k → MIO_ready high in the cycle after edge k+1+WAIT_CYCLES. With WAIT_CYCLES=0 this is 2 cycles.
- Back-to-back: if CPU_MIO is still high in the IDLE cycle after RESP, a new transaction starts; this is one idle cycle between pulses. Inputs that change while the FSM is in WAIT, ACCESS or RESP are ignored; only the values latched in IDLE are used.
- Data_in holds its last value until the next RESP. A write response drives Data_in=0.
- Address decode on latched addr:
  - RAM hit: addr < DEPTH*4; word index addr[log2(DEPTH)+1:2].
  - IO_BASE+0: gpio_out, R/W; read returns {16'b0, gpio_out}; write takes wdata[15:0].
  - IO_BASE+4: gpio_in, read-only; read returns {16'b0, gpio_in}; writes ignored.
  - IO_BASE+8: free-running 32-bit cycle counter; increments every cycle and wraps 32'hFFFF_FFFF→0. A write clears it to 0 on the ACCESS edge, and it increments from 0 afterwards.
  - Anything else: unmapped. Read returns 0, write is discarded, and bus_err pulses in the RESP cycle. MIO_ready still pulses, so the CPU never hangs.
- Reset mid-transaction: transaction aborted, no MIO_ready. A write is committed only if the ACCESS edge occurred before reset was asserted.

Optional Feature:
- Macro MIO_FAST_WRITE_EN.
- Defined: writes skip WAIT and go IDLE→ACCESS directly, so write latency is always 2 cycles. Reads still use WAIT_CYCLES.
- Undefined: reads and writes use identical timing per WAIT_CYCLES.

Test Plan:
- Reset, then idle 5 cycles → Data_in=0, MIO_ready=0, gpio_out=0, bus_err=0. Read IO_BASE+8 → small nonzero count, consistent with cycles elapsed.
- WAIT_CYCLES=2: write 32'hCAFE_F00D to 0x10, then read 0x10 → each MIO_ready arrives 4 cycles after the request edge, is 1 cycle wide, and the read returns 32'hCAFE_F00D.
- Write 32'h0001_A5A5 to IO_BASE+0 → gpio_out=16'hA5A5. Set gpio_in=16'h1234 and read IO_BASE+4 → Data_in=32'h0000_1234.
- Read 32'h8000_0000 (unmapped) → Data_in=0, MIO_ready and bus_err both pulse in the same cycle. A write there leaves the RAM and all registers unchanged.
- CPU_MIO held high for 3 consecutive reads of 0x0, 0x4, 0x8 → 3 MIO_ready pulses separated by exactly 1 idle cycle, with correct data order. Drive reset low during WAIT of a write → no MIO_ready and RAM unchanged.
- With MIO_FAST_WRITE_EN defined and WAIT_CYCLES=3: write latency is 2 cycles and read latency is 5 cycles.
